// File: rtl/fb_fill.sv
// Rectangle-fill engine: clips a command to the visible screen and streams raster-order pixel writes.
// Optional build macro FB_FILL_VSYNC_WAIT_EN holds each fill until the next vsync falling edge.
module fb_fill #(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int HW    = 10,
   parameter int VW    = 9,
   parameter int DW    = 24
) (
   input  logic          clk_i,
   input  logic          rst_i,        // active low
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [HW-1:0] cmd_x0_i,
   input  logic [VW-1:0] cmd_y0_i,
   input  logic [HW-1:0] cmd_w_i,
   input  logic [VW-1:0] cmd_h_i,
   input  logic [DW-1:0] cmd_color_i,
   input  logic          vsync_i,
   output logic          wr_en_o,
   input  logic          wr_ready_i,
   output logic [HW-1:0] wr_h_addr_o,
   output logic [VW-1:0] wr_v_addr_o,
   output logic [DW-1:0] wr_data_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam logic [HW:0] H_LIM = (HW+1)'(H_RES);
   localparam logic [VW:0] V_LIM = (VW+1)'(V_RES);

`ifdef FB_FILL_VSYNC_WAIT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd2, DONE = 2'd3} state_t;
`endif

   state_t        state_q, state_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          wr_en_q, wr_en_d;
   logic [HW-1:0] wr_h_q, wr_h_d;
   logic [VW-1:0] wr_v_q, wr_v_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [HW-1:0] x0_q, x0_d;
   logic [HW-1:0] xend_q, xend_d;
   logic [VW-1:0] yend_q, yend_d;

   // Clipping in one extra bit so H_RES-x0 and x0+w_eff cannot wrap.
   logic          x_off, y_off, empty, vs_fall;
   logic [HW:0]   rem_w, w_eff, xend_sum;
   logic [VW:0]   rem_h, h_eff, yend_sum;

   always_comb begin
      x_off    = {1'b0, cmd_x0_i} >= H_LIM;
      y_off    = {1'b0, cmd_y0_i} >= V_LIM;
      rem_w    = x_off ? '0 : H_LIM - {1'b0, cmd_x0_i};
      rem_h    = y_off ? '0 : V_LIM - {1'b0, cmd_y0_i};
      w_eff    = ({1'b0, cmd_w_i} < rem_w) ? {1'b0, cmd_w_i} : rem_w;
      h_eff    = ({1'b0, cmd_h_i} < rem_h) ? {1'b0, cmd_h_i} : rem_h;
      empty    = x_off | y_off | (w_eff == '0) | (h_eff == '0);
      xend_sum = {1'b0, cmd_x0_i} + w_eff - (HW+1)'(1);
      yend_sum = {1'b0, cmd_y0_i} + h_eff - (VW+1)'(1);
   end

`ifdef FB_FILL_VSYNC_WAIT_EN
   logic vs_prev_q;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) vs_prev_q <= 1'b1;
      else        vs_prev_q <= vsync_i;
   end
   assign vs_fall = vs_prev_q & ~vsync_i;
`else
   logic unused_vsync;
   assign unused_vsync = vsync_i;
   assign vs_fall      = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      wr_en_d     = wr_en_q;
      wr_h_d      = wr_h_q;
      wr_v_d      = wr_v_q;
      wr_data_d   = wr_data_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      x0_d        = x0_q;
      xend_d      = xend_q;
      yend_d      = yend_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               if (empty) begin
                  // Address outputs left alone so an off-screen origin never shows up on them.
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  x0_d      = cmd_x0_i;
                  xend_d    = xend_sum[HW-1:0];
                  yend_d    = yend_sum[VW-1:0];
                  wr_h_d    = cmd_x0_i;
                  wr_v_d    = cmd_y0_i;
                  wr_data_d = cmd_color_i;
`ifdef FB_FILL_VSYNC_WAIT_EN
                  state_d   = WAIT_VS;
`else
                  state_d   = FILL;
                  wr_en_d   = 1'b1;
`endif
               end
            end
         end
`ifdef FB_FILL_VSYNC_WAIT_EN
         WAIT_VS: begin
            if (vs_fall) begin
               state_d = FILL;
               wr_en_d = 1'b1;
            end
         end
`endif
         FILL: begin
            if (wr_ready_i) begin
               if (wr_h_q == xend_q) begin
                  if (wr_v_q == yend_q) begin
                     wr_en_d = 1'b0;
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     wr_h_d = x0_q;
                     wr_v_d = wr_v_q + VW'(1);
                  end
               end else begin
                  wr_h_d = wr_h_q + HW'(1);
               end
            end
         end
         DONE: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
            wr_en_d     = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
      if (vs_fall && 1'b0) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         wr_en_q     <= 1'b0;
         wr_h_q      <= '0;
         wr_v_q      <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         x0_q        <= '0;
         xend_q      <= '0;
         yend_q      <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         wr_en_q     <= wr_en_d;
         wr_h_q      <= wr_h_d;
         wr_v_q      <= wr_v_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         x0_q        <= x0_d;
         xend_q      <= xend_d;
         yend_q      <= yend_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign wr_en_o     = wr_en_q;
   assign wr_h_addr_o = wr_h_q;
   assign wr_v_addr_o = wr_v_q;
   assign wr_data_o   = wr_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_fb_fill.sv
// Directed bench for fb_fill: reset abort, raster order, clipping, empty commands, write stalls.
module tb_fb_fill;

   logic        clk, rst, cmd_valid, cmd_ready, vsync, wr_en, wr_ready, busy, done;
   logic [9:0]  cmd_x0, cmd_w, wr_h;
   logic [8:0]  cmd_y0, cmd_h, wr_v;
   logic [23:0] cmd_color, wr_data;

`ifdef FB_FILL_VSYNC_WAIT_EN
   localparam int VS_OFF = 10;
`else
   localparam int VS_OFF = 0;
`endif
   localparam int VS_HI = 10;

   fb_fill dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_w_i(cmd_w), .cmd_h_i(cmd_h),
      .cmd_color_i(cmd_color), .vsync_i(vsync), .wr_en_o(wr_en), .wr_ready_i(wr_ready),
      .wr_h_addr_o(wr_h), .wr_v_addr_o(wr_v), .wr_data_o(wr_data),
      .busy_o(busy), .done_o(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int nw, first_en, done_cyc, done_cnt, busy_cnt, hold_cnt, oob;
   int wx [0:63];
   int wy [0:63];
   logic [23:0] wd [0:63];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic present(input int x, input int y, input int w, input int h, input logic [23:0] c);
      @(negedge clk);
      chk("rdy_before_cmd", {31'd0, cmd_ready}, 1);
      cmd_valid = 1'b1;
      cmd_x0 = 10'(x); cmd_y0 = 9'(y); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = c;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_x0 = 10'h3a5; cmd_y0 = 9'h15a; cmd_w = 10'h2f; cmd_h = 9'h33; cmd_color = 24'h5a5a5a;
   endtask

   task automatic run_cmd(input int x, input int y, input int w, input int h,
                          input logic [23:0] c, input int stall);
      int stall_left;
      nw = 0; first_en = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; hold_cnt = 0; oob = 0;
      wr_ready = 1'b1;
      present(x, y, w, h, c);
      stall_left = stall;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (wr_en) begin
            if (first_en < 0) first_en = k;
            if (wr_h >= 10'd640 || wr_v >= 9'd480) oob = 1;
            if (int'(wr_h) == x && int'(wr_v) == y && wr_data == c) hold_cnt++;
            if (stall_left > 0) begin
               wr_ready = 1'b0;
               stall_left--;
            end else begin
               wr_ready = 1'b1;
               if (nw < 64) begin
                  wx[nw] = int'(wr_h); wy[nw] = int'(wr_v); wd[nw] = wr_data;
               end
               nw++;
            end
         end else begin
            wr_ready = 1'b1;
         end
         if (VS_OFF != 0 && k == VS_HI) vsync = 1'b0;
         if (done_cyc > 0 && k == done_cyc + 1) begin
            chk("rdy_after_done", {31'd0, cmd_ready}, 1);
            chk("done_one_cycle", {31'd0, done}, 0);
            break;
         end
      end
      vsync = 1'b1;
      chk("done_seen", {31'd0, (done_cyc > 0)}, 1);
   endtask

   initial begin
      int found, dn;
      rst = 1'b0; cmd_valid = 1'b0; vsync = 1'b1; wr_ready = 1'b1;
      cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("rst_wr_en", {31'd0, wr_en}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_addr", {13'd0, wr_h, wr_v}, 0);
      chk("rst_data", {8'd0, wr_data}, 0);
      rst = 1'b1;

      // abort a 4x4 fill while pixel 2 is on the port
      present(0, 0, 4, 4, 24'h123456);
      found = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (VS_OFF != 0 && k == VS_HI) vsync = 1'b0;
         if (wr_en && wr_h == 10'd2 && wr_v == 9'd0) begin
            found = 1;
            break;
         end
      end
      chk("midrst_reached_px2", found, 1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_wr_en_async", {31'd0, wr_en}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      @(negedge clk);
      #2 rst = 1'b1; vsync = 1'b1;
      dn = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) dn = 1;
      end
      chk("midrst_no_done", dn, 0);
      chk("midrst_wr_en_after", {31'd0, wr_en}, 0);
      chk("midrst_ready_after", {31'd0, cmd_ready}, 1);

      // 3x2 at (10,20), red
      run_cmd(10, 20, 3, 2, 24'hFF0000, 0);
      chk("r32_nw", nw, 6);
      chk("r32_first_en", first_en, 1 + VS_OFF);
      chk("r32_done_cyc", done_cyc, 7 + VS_OFF);
      chk("r32_busy_cyc", busy_cnt, 7 + VS_OFF);
      chk("r32_done_cnt", done_cnt, 1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("r32_x%0d", i), wx[i], 10 + i % 3);
         chk($sformatf("r32_y%0d", i), wy[i], 20 + i / 3);
         chk($sformatf("r32_d%0d", i), {8'd0, wd[i]}, 32'h00FF0000);
      end

      // clipped at the bottom-right corner
      run_cmd(638, 479, 5, 3, 24'h0000FF, 0);
      chk("clip_nw", nw, 2);
      chk("clip_oob", oob, 0);
      chk("clip_x0", wx[0], 638);
      chk("clip_y0", wy[0], 479);
      chk("clip_x1", wx[1], 639);
      chk("clip_y1", wy[1], 479);
      chk("clip_done_cyc", done_cyc, 3 + VS_OFF);

      // zero width
      run_cmd(5, 5, 0, 4, 24'hABCDEF, 0);
      chk("w0_no_en", first_en, -1);
      chk("w0_done_cyc", done_cyc, 1);
      chk("w0_busy", busy_cnt, 1);

      // origin off-screen
      run_cmd(700, 10, 5, 5, 24'hABCDEF, 0);
      chk("xoff_no_en", first_en, -1);
      chk("xoff_done_cyc", done_cyc, 1);
      chk("xoff_oob", oob, 0);

      // 2x1 with the first pixel stalled for 3 cycles
      run_cmd(100, 50, 2, 1, 24'h00FF00, 3);
      chk("stall_hold", hold_cnt, 4);
      chk("stall_nw", nw, 2);
      chk("stall_x0", wx[0], 100);
      chk("stall_x1", wx[1], 101);
      chk("stall_y1", wy[1], 50);
      chk("stall_done_cyc", done_cyc, 6 + VS_OFF);
      chk("stall_done_cnt", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
